// File: rtl/psum_dequant_loader_pkg.sv
// Shared definitions for the psum dequant loader.
//   Lane geometry: ARRAY_SIZE lanes, OUTPUT_DATA_WIDTH quantized (Q8.8) lanes
//   in SRAM, ORI_WIDTH accumulator lanes (Q13.8) into the systolic array.
//   FSM state encoding and the packed accumulator row type.
package psum_dequant_loader_pkg;

  localparam int ARRAY_SIZE        = 8;
  localparam int DATA_WIDTH        = 8;
  localparam int OUTPUT_DATA_WIDTH = 16;
  localparam int CUM_BITS_EXT      = 5;
  localparam int ORI_WIDTH         = DATA_WIDTH*2 + CUM_BITS_EXT;
  localparam int ADDR_WIDTH        = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Lane i occupies bits [i*ORI_WIDTH +: ORI_WIDTH] when flattened.
  typedef logic [ARRAY_SIZE-1:0][ORI_WIDTH-1:0] acc_row_t;

endpackage

// File: rtl/psum_sign_extend.sv
// Per-lane dequantize: sign-extends one stored Q8.8 lane to the accumulator
// width. The binary point does not move, so this is the exact inverse of the
// saturating quantize stage for every value that did not saturate.
//   din   in   IN_W    quantized lane (signed)
//   dout  out  OUT_W   accumulator lane (signed)
module psum_sign_extend #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 21
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  assign dout = {{(OUT_W-IN_W){din[IN_W-1]}}, din};

endmodule

// File: rtl/psum_dequant_loader.sv
// Streams quantized partial-sum rows out of SRAM, sign-extends every lane to
// the accumulator width and hands the rows to the systolic array's psum
// preload port over valid/ready. Used to resume accumulation across K-tiles.
//   clk, srstn      clock (rising) and asynchronous active-low reset
//   start           1-cycle pulse, latches base_addr/num_rows when idle
//   base_addr       first SRAM row of the job
//   num_rows        rows in the job, 0 = empty job
//   busy / done     job in progress / 1-cycle completion pulse
//   sram_ren/raddr  SRAM read port; sram_rdata valid 1 cycle after sram_ren
//   psum_valid/ready/data   preload handshake, lane i at [i*ORI_WIDTH +: ORI_WIDTH]
module psum_dequant_loader
  import psum_dequant_loader_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  srstn,
  input  logic                                  start,
  input  logic [ADDR_WIDTH-1:0]                 base_addr,
  input  logic [ADDR_WIDTH-1:0]                 num_rows,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  sram_ren,
  output logic [ADDR_WIDTH-1:0]                 sram_raddr,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata,
  output logic                                  psum_valid,
  input  logic                                  psum_ready,
  output logic [ARRAY_SIZE*ORI_WIDTH-1:0]       psum_data
);

  state_t                state;
  logic                  busy_q, done_q;
  logic [ADDR_WIDTH-1:0] addr_q;    // next row to read
  logic [ADDR_WIDTH-1:0] rem_q;     // reads still to issue

  // read issued last cycle: its data is on sram_rdata this cycle
  logic                  rd_pend;

  // 2-entry output FIFO, head drives psum_data directly
  acc_row_t              fifo_mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fifo_cnt;

  acc_row_t              rdata_ext;
  logic                  push, pop, issue;
  logic [1:0]            credit_used;
  logic [1:0]            cnt_after_pop;

  // ---------------------------------------------------------------------
  // Dequantize on the FIFO input path, one sign-extender per lane
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    psum_sign_extend #(
      .IN_W  (OUTPUT_DATA_WIDTH),
      .OUT_W (ORI_WIDTH)
    ) u_sext (
      .din  (sram_rdata[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]),
      .dout (rdata_ext[i])
    );
  end

  // ---------------------------------------------------------------------
  // Credit / issue
  // ---------------------------------------------------------------------
  assign push = rd_pend;
  assign pop  = (fifo_cnt != 2'd0) && psum_ready;

  // Occupancy once this cycle's pop and landing data are accounted for.
  // Counting the pop is what lets a new read go out every cycle while the
  // array keeps psum_ready high; without a pop the limit of two keeps the
  // returning data from ever finding the FIFO full.
  assign cnt_after_pop = fifo_cnt - {1'b0, pop};
  assign credit_used   = cnt_after_pop + {1'b0, rd_pend};
  assign issue         = (state == ST_READ) && (credit_used < 2'd2);

  assign sram_ren   = issue;
  assign sram_raddr = addr_q;

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) rd_pend <= 1'b0;
    else        rd_pend <= issue;
  end

  // ---------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= rdata_ext;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign psum_valid = (fifo_cnt != 2'd0);
  assign psum_data  = fifo_mem[rd_ptr];

  // ---------------------------------------------------------------------
  // Job FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q <= base_addr;
            rem_q  <= num_rows;
            if (num_rows == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state  <= ST_READ;
              busy_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (issue) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);   // wraps modulo 2^ADDR_WIDTH
            rem_q  <= rem_q - ADDR_WIDTH'(1);
            if (rem_q == ADDR_WIDTH'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Leave on the final pop itself so done lands the next cycle.
          if (!rd_pend && (cnt_after_pop == 2'd0)) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule
